// File: rtl/frame_pkg.sv
// frame_pkg: shared frame geometry, pointer widths and buffer states.
package frame_pkg;
   localparam int IMG_W     = 64;
   localparam int IMG_H     = 64;
   localparam int PIX_W     = 8;
   localparam int FRAME_PIX = IMG_W * IMG_H;
   localparam int ADDR_W    = 12;
   localparam int ROW_W     = 6;
   localparam int COL_W     = 6;
   typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_t;
endpackage

// File: rtl/frame_ram.sv
// frame_ram: simple dual-port frame store, one write and one registered read port.
module frame_ram import frame_pkg::*; #(
   parameter int DEPTH = FRAME_PIX,
   parameter int DW    = PIX_W,
   parameter int AW    = ADDR_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/frame_result_buffer.sv
// frame_result_buffer: captures one raster result frame, then replays it
// row-major under a pausable request handshake with 1-cycle read latency.
module frame_result_buffer import frame_pkg::*; #(
   parameter int IMG_W = frame_pkg::IMG_W,
   parameter int IMG_H = frame_pkg::IMG_H,
   parameter int PIX_W = frame_pkg::PIX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [PIX_W-1:0] pixelw,
   output logic             wr_ready,
   output logic             full,
   input  logic             rd_req,
   output logic [PIX_W-1:0] pixel_out,
   output logic             pixel_valid,
   output logic [ROW_W-1:0] out_row,
   output logic [COL_W-1:0] out_col,
   output logic             frame_done,
   output logic             ovf
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
   state_t            state, state_n;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [PIX_W-1:0]  ram_q;
   logic              we, re, last_wr, last_rd;
   assign wr_ready  = state == IDLE || state == FILL;
   assign full      = state == FULL || state == DRAIN;
   assign we        = wr && wr_ready;
   assign re        = rd_req && full;
   assign last_wr   = we && wr_ptr == LAST;
   assign last_rd   = re && rd_ptr == LAST;
   assign pixel_out = pixel_valid ? ram_q : '0;
   frame_ram #(.DEPTH(IMG_W * IMG_H), .DW(PIX_W), .AW(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr),
      .wdata (pixelw),
      .re    (re),
      .raddr (rd_ptr),
      .rdata (ram_q)
   );
   always_comb begin
      state_n = state;
      if (last_rd) state_n = IDLE;
      else if (re) state_n = DRAIN;
      else if (last_wr) state_n = FULL;
      else if (we) state_n = FILL;
   end
   // row/col are taken from the issued read address and held through pauses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ovf         <= 1'b0;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         out_row     <= '0;
         out_col     <= '0;
      end else begin
         state       <= state_n;
         wr_ptr      <= last_wr ? '0 : wr_ptr + ADDR_W'(we);
         rd_ptr      <= last_rd ? '0 : rd_ptr + ADDR_W'(re);
         ovf         <= ovf | (wr & ~wr_ready);
         pixel_valid <= re;
         frame_done  <= last_rd;
         if (re) begin
            out_row <= rd_ptr[ADDR_W-1:COL_W];
            out_col <= rd_ptr[COL_W-1:0];
         end
      end
   end
endmodule

// File: tb/tb_frame_result_buffer.sv
// tb_frame_result_buffer: directed self-checking bench for frame_result_buffer.
module tb_frame_result_buffer;
   localparam int NPIX = 4096;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] pixelw = '0;
   logic       rd_req = 1'b0;
   logic       wr_ready, full, pixel_valid, frame_done, ovf;
   logic [7:0] pixel_out;
   logic [5:0] out_row, out_col;
   logic [7:0] model [NPIX];
   int         n_chk = 0;
   int         n_fail = 0;

   frame_result_buffer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr          (wr),
      .pixelw      (pixelw),
      .wr_ready    (wr_ready),
      .full        (full),
      .rd_req      (rd_req),
      .pixel_out   (pixel_out),
      .pixel_valid (pixel_valid),
      .out_row     (out_row),
      .out_col     (out_col),
      .frame_done  (frame_done),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int from, input int to, input int mode);
      for (int a = from; a < to; a++) begin
         wr = 1'b1;
         pixelw = mode == 0 ? 8'(a) : mode == 1 ? 8'(a) ^ 8'h5C : mode == 2 ? 8'(a * 3 + 7) : 8'h11;
         model[a] = pixelw;
         step();
      end
      wr = 1'b0;
   endtask

   task automatic drain_all(output int bad, output int dones);
      bad = 0;
      dones = 0;
      rd_req = 1'b1;
      for (int i = 0; i < NPIX; i++) begin
         step();
         if (pixel_valid !== 1'b1 || pixel_out !== model[i] || out_row !== 6'(i / 64) || out_col !== 6'(i % 64)) bad++;
         if (frame_done) dones++;
         if (frame_done !== (i == NPIX - 1)) bad++;
      end
      rd_req = 1'b0;
   endtask

   initial begin
      int bad, dones, cnt, rd_i;
      logic [4:0] pat;
      pat = 5'b01101;
      step();
      step();
      rst_n = 1'b1;
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_valid", 32'(pixel_valid), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_pix_row_col", {12'd0, pixel_out, out_row, out_col}, 32'd0);
      rd_req = 1'b1;
      step();
      chk("idle_rd_ignored", 32'(pixel_valid), 32'd0);
      fill(0, NPIX - 1, 0);
      chk("fill_rd_ignored", 32'(pixel_valid), 32'd0);
      chk("full_before_last", 32'(full), 32'd0);
      rd_req = 1'b0;
      fill(NPIX - 1, NPIX, 0);
      chk("full_after_last", 32'(full), 32'd1);
      chk("wr_ready_full", 32'(wr_ready), 32'd0);
      step();
      chk("full_holds", 32'(full), 32'd1);
      rd_req = 1'b1;
      for (int i = 0; i < 331; i++) step();
      chk("pix_5_10", {16'd0, pixel_out}, 32'h4A);
      chk("row_5_10", 32'(out_row), 32'd5);
      chk("col_5_10", 32'(out_col), 32'd10);
      chk("done_mid", 32'(frame_done), 32'd0);
      for (int i = 331; i < NPIX; i++) step();
      chk("last_pix", {16'd0, pixel_out}, 32'hFF);
      chk("last_rc", {20'd0, out_row, out_col}, {20'd0, 6'd63, 6'd63});
      chk("last_done", 32'(frame_done), 32'd1);
      chk("idle_after_drain", {30'd0, wr_ready, full}, 32'b10);
      rd_req = 1'b0;
      step();
      chk("valid_after_drain", {30'd0, pixel_valid, frame_done}, 32'd0);

      bad = 0;
      cnt = 0;
      for (int t = 0; t < 20000 && cnt < NPIX; t++) begin
         wr = $urandom_range(0, 9) >= 3;
         pixelw = 8'($urandom);
         if (wr) model[cnt] = pixelw;
         step();
         if (wr) cnt++;
         if (full !== (cnt == NPIX)) bad++;
      end
      wr = 1'b0;
      chk("rand_fill_count", 32'(cnt), 32'(NPIX));
      chk("rand_fill_full", 32'(bad), 32'd0);

      bad = 0;
      rd_i = 0;
      for (int t = 0; t < 20000 && rd_i < NPIX; t++) begin
         rd_req = pat[t % 5];
         step();
         if (rd_req) begin
            if (pixel_valid !== 1'b1 || pixel_out !== model[rd_i] || out_row !== 6'(rd_i / 64) || out_col !== 6'(rd_i % 64)) bad++;
            if (frame_done !== (rd_i == NPIX - 1)) bad++;
            rd_i++;
         end else if (pixel_valid !== 1'b0 || pixel_out !== 8'd0 || frame_done !== 1'b0 || out_row !== 6'((rd_i - 1) / 64) || out_col !== 6'((rd_i - 1) % 64)) bad++;
      end
      rd_req = 1'b0;
      chk("toggle_drain_count", 32'(rd_i), 32'(NPIX));
      chk("toggle_drain_data", 32'(bad), 32'd0);
      step();
      chk("toggle_idle", {30'd0, wr_ready, full}, 32'b10);

      fill(0, NPIX, 1);
      wr = 1'b1;
      pixelw = 8'hAA;
      step();
      chk("ovf_set", 32'(ovf), 32'd1);
      chk("ovf_full_holds", 32'(full), 32'd1);
      wr = 1'b0;
      step();
      chk("ovf_sticky", 32'(ovf), 32'd1);
      wr = 1'b1;
      rd_req = 1'b1;
      step();
      wr = 1'b0;
      rd_req = 1'b0;
      chk("sim_rd_valid", 32'(pixel_valid), 32'd1);
      chk("ram_unchanged", {16'd0, pixel_out}, 32'h5C);
      chk("sim_ovf", 32'(ovf), 32'd1);
      rd_req = 1'b1;
      step();
      chk("drain_pix1", {16'd0, pixel_out}, {24'd0, 8'h01 ^ 8'h5C});
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      rd_req = 1'b0;
      chk("rst_drain_valid", 32'(pixel_valid), 32'd0);
      chk("rst_drain_state", {29'd0, wr_ready, full, ovf}, 32'b100);

      fill(0, 2000, 3);
      chk("midfill_full", 32'(full), 32'd0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      fill(0, NPIX - 1, 2);
      chk("refill_not_full", 32'(full), 32'd0);
      fill(NPIX - 1, NPIX, 2);
      chk("refill_full", 32'(full), 32'd1);
      drain_all(bad, dones);
      chk("refill_readback", 32'(bad), 32'd0);
      chk("refill_done_once", 32'(dones), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
